// File: rtl/turn_scheduler_pkg.sv
// Shared direction codes, FSM state type and direction helpers for the
// turn scheduler and the snake movement/collision logic.
// Optional feature macro: TURN_SCHEDULER_PAUSE_EN adds the S_PAUSE state.
package turn_scheduler_pkg;

  localparam logic [4:0] DIR_IDLE  = 5'b10000;
  localparam logic [4:0] DIR_UP    = 5'b01000;
  localparam logic [4:0] DIR_LEFT  = 5'b00100;
  localparam logic [4:0] DIR_DOWN  = 5'b00010;
  localparam logic [4:0] DIR_RIGHT = 5'b00001;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
`ifdef TURN_SCHEDULER_PAUSE_EN
    S_PAUSE = 2'd2,
`endif
    S_RUN   = 2'd1
  } state_t;

  // True only for exactly one of the four movement codes.
  function automatic logic is_dir(input logic [4:0] code);
    return (code == DIR_UP) || (code == DIR_LEFT) ||
           (code == DIR_DOWN) || (code == DIR_RIGHT);
  endfunction

  // Reverse of a movement code; non-movement codes map to themselves.
  function automatic logic [4:0] opposite(input logic [4:0] code);
    logic [4:0] r;
    case (code)
      DIR_UP:    r = DIR_DOWN;
      DIR_DOWN:  r = DIR_UP;
      DIR_LEFT:  r = DIR_RIGHT;
      DIR_RIGHT: r = DIR_LEFT;
      default:   r = code;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/turn_scheduler_dir_fifo.sv
// dir_fifo: 5-bit synchronous FIFO for queued turns.
// Ports:
//   clk, reset_n     clock, synchronous active-low reset
//   push, din        write din at the tail (ignored when full without pop)
//   pop              drop the head entry (ignored when empty)
//   flush            empty the queue; wins over push/pop
//   dout             head entry
//   tail             most recently written entry (valid when not empty)
//   count            occupancy, AW+1 bits
//   full, empty      occupancy flags; full is registered
module dir_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [4:0]    din,
  output logic [4:0]    dout,
  output logic [4:0]    tail,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [4:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count_next;
  logic          push_ok;
  logic          pop_ok;

  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];
  assign tail  = mem[wr_ptr - AW'(1)];

  // Pop is evaluated first so a full queue can accept a push in the same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    count_next = count;
    if (flush)
      count_next = '0;
    else if (push_ok && !pop_ok)
      count_next = count + (AW+1)'(1);
    else if (pop_ok && !push_ok)
      count_next = count - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (pop_ok)
          rd_ptr <= rd_ptr + AW'(1);
        if (push_ok) begin
          mem[wr_ptr] <= din;
          wr_ptr      <= wr_ptr + AW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/turn_scheduler.sv
// turn_scheduler: arbitrates button/keyboard turn requests, queues them in a
// small FIFO and applies at most one turn per game tick.
// Optional feature macro: TURN_SCHEDULER_PAUSE_EN (pause freezes stepping).
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   btn_dir, btn_valid    button request (wins arbitration)
//   kbd_dir, kbd_valid    keyboard request
//   tick                  game-step pulse
//   game_over             return to idle, flush queue, clear overflow
//   pause                 freeze stepping (only with the macro)
//   direction             registered one-hot current direction
//   move_strobe           one-cycle pulse one cycle after a running tick
//   queue_full            FIFO holds DEPTH entries
//   overflow              sticky: a request was dropped
module turn_scheduler
  import turn_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] btn_dir,
  input  logic       btn_valid,
  input  logic [4:0] kbd_dir,
  input  logic       kbd_valid,
  input  logic       tick,
  input  logic       game_over,
  input  logic       pause,
  output logic [4:0] direction,
  output logic       move_strobe,
  output logic       queue_full,
  output logic       overflow
);

  state_t      state;
  logic [4:0]  req_dir;
  logic        req_valid;
  logic        arb_drop;
  logic        dup;
  logic        step_ok;
  logic        pop;
  logic        push;
  logic        full_drop;
  logic [4:0]  fifo_head;
  logic [4:0]  fifo_tail;
  logic        fifo_full;
  logic        fifo_empty;
  logic [AW:0] fifo_count_unused;

`ifndef TURN_SCHEDULER_PAUSE_EN
  logic pause_unused;
  assign pause_unused = pause;
`endif

  always_comb begin
    req_dir   = btn_valid ? btn_dir : kbd_dir;
    req_valid = (btn_valid || kbd_valid) && is_dir(req_dir);
    arb_drop  = btn_valid && kbd_valid && is_dir(kbd_dir);

    // Redundant requests: equal to the queued tail, or to the live
    // direction when nothing is queued.
    dup = fifo_empty ? (req_dir == direction) : (req_dir == fifo_tail);

`ifdef TURN_SCHEDULER_PAUSE_EN
    step_ok = (state == S_IDLE) || ((state == S_RUN) && !pause);
`else
    step_ok = 1'b1;
`endif

    pop       = tick && step_ok && !fifo_empty && !game_over;
    push      = req_valid && !dup && (!fifo_full || pop) && !game_over;
    full_drop = req_valid && !dup && fifo_full && !pop && !game_over;
  end

  dir_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (game_over),
    .din     (req_dir),
    .dout    (fifo_head),
    .tail    (fifo_tail),
    .count   (fifo_count_unused),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign queue_full = fifo_full;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      direction   <= DIR_IDLE;
      move_strobe <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      move_strobe <= 1'b0;
      if (game_over) begin
        state     <= S_IDLE;
        direction <= DIR_IDLE;
        overflow  <= 1'b0;
      end else begin
        if (arb_drop || full_drop)
          overflow <= 1'b1;
        case (state)
          S_IDLE: begin
            if (tick && !fifo_empty) begin
              direction   <= fifo_head;
              move_strobe <= 1'b1;
              state       <= S_RUN;
            end
          end
          S_RUN: begin
`ifdef TURN_SCHEDULER_PAUSE_EN
            if (pause)
              state <= S_PAUSE;
            else
`endif
            if (tick) begin
              move_strobe <= 1'b1;
              // A reversal is popped but discarded, spending this tick's turn.
              if (!fifo_empty && (fifo_head != opposite(direction)))
                direction <= fifo_head;
            end
          end
`ifdef TURN_SCHEDULER_PAUSE_EN
          S_PAUSE: begin
            if (!pause)
              state <= S_RUN;
          end
`endif
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed self-checking bench for turn_scheduler.
module tb_turn_scheduler;

  localparam logic [4:0] IDLE  = 5'b10000;
  localparam logic [4:0] UP    = 5'b01000;
  localparam logic [4:0] LEFT  = 5'b00100;
  localparam logic [4:0] DOWN  = 5'b00010;
  localparam logic [4:0] RIGHT = 5'b00001;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] btn_dir;
  logic       btn_valid;
  logic [4:0] kbd_dir;
  logic       kbd_valid;
  logic       tick;
  logic       game_over;
  logic       pause;
  logic [4:0] direction;
  logic       move_strobe;
  logic       queue_full;
  logic       overflow;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  turn_scheduler #(.DEPTH(4), .AW(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_dir     (btn_dir),
    .btn_valid   (btn_valid),
    .kbd_dir     (kbd_dir),
    .kbd_valid   (kbd_valid),
    .tick        (tick),
    .game_over   (game_over),
    .pause       (pause),
    .direction   (direction),
    .move_strobe (move_strobe),
    .queue_full  (queue_full),
    .overflow    (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_btn(input logic [4:0] d);
    btn_dir = d; btn_valid = 1'b1;
    step();
    btn_valid = 1'b0;
  endtask

  task automatic press_kbd(input logic [4:0] d);
    kbd_dir = d; kbd_valid = 1'b1;
    step();
    kbd_valid = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; btn_dir = '0; btn_valid = 1'b0; kbd_dir = '0; kbd_valid = 1'b0;
    tick = 1'b0; game_over = 1'b0; pause = 1'b0;
    step(); step();
    check("rst_dir", 32'(direction), 32'(IDLE));
    check("rst_strobe", 32'(move_strobe), 32'd0);
    check("rst_full", 32'(queue_full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    step();

    // Idle with empty queue: tick does nothing
    do_tick();
    check("idle_empty_dir", 32'(direction), 32'(IDLE));
    check("idle_empty_strobe", 32'(move_strobe), 32'd0);

    // Malformed code ignored
    press_btn(5'b00011);
    do_tick();
    check("bad_code_dir", 32'(direction), 32'(IDLE));

    // 1. first turn from idle
    press_btn(UP);
    do_tick();
    check("t1_dir", 32'(direction), 32'(UP));
    check("t1_strobe", 32'(move_strobe), 32'd1);
    step();
    check("t1_strobe_low", 32'(move_strobe), 32'd0);

    // 2. reversal discarded, strobe still issued
    press_btn(DOWN);
    do_tick();
    check("t2_dir", 32'(direction), 32'(UP));
    check("t2_strobe", 32'(move_strobe), 32'd1);
    do_tick();
    check("t2_empty_dir", 32'(direction), 32'(UP));
    check("t2_empty_strobe", 32'(move_strobe), 32'd1);

    // 3. two queued turns, one per tick
    press_btn(LEFT);
    press_btn(DOWN);
    do_tick();
    check("t3_dir1", 32'(direction), 32'(LEFT));
    do_tick();
    check("t3_dir2", 32'(direction), 32'(DOWN));

    // 4. simultaneous requests: button wins
    btn_dir = RIGHT; btn_valid = 1'b1; kbd_dir = LEFT; kbd_valid = 1'b1;
    step();
    btn_valid = 1'b0; kbd_valid = 1'b0;
    check("t4_ovf", 32'(overflow), 32'd1);
    do_tick();
    check("t4_dir", 32'(direction), 32'(RIGHT));
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    check("t4_go_dir", 32'(direction), 32'(IDLE));
    check("t4_go_ovf", 32'(overflow), 32'd0);

    // 5. fill queue, overflow when full, full push+pop
    press_btn(UP);
    press_kbd(LEFT);
    press_btn(DOWN);
    check("t5_not_full", 32'(queue_full), 32'd0);
    press_btn(RIGHT);
    check("t5_full", 32'(queue_full), 32'd1);
    check("t5_no_ovf", 32'(overflow), 32'd0);
    press_btn(UP);
    check("t5_drop_ovf", 32'(overflow), 32'd1);
    check("t5_still_full", 32'(queue_full), 32'd1);
    btn_dir = LEFT; btn_valid = 1'b1; tick = 1'b1;
    step();
    btn_valid = 1'b0; tick = 1'b0;
    check("t5_pp_dir", 32'(direction), 32'(UP));
    check("t5_pp_strobe", 32'(move_strobe), 32'd1);
    check("t5_pp_full", 32'(queue_full), 32'd1);
    // queue now LEFT, DOWN, RIGHT, LEFT
    do_tick();
    check("t5_q1", 32'(direction), 32'(LEFT));
    check("t5_q1_full", 32'(queue_full), 32'd0);
    do_tick();
    check("t5_q2", 32'(direction), 32'(DOWN));
    do_tick();
    check("t5_q3", 32'(direction), 32'(RIGHT));
    do_tick();
    check("t5_q4_rev", 32'(direction), 32'(RIGHT));
    check("t5_ovf_sticky", 32'(overflow), 32'd1);

    // 6. game_over beats tick with 3 queued
    press_btn(UP);
    press_btn(LEFT);
    press_btn(DOWN);
    game_over = 1'b1; tick = 1'b1;
    step();
    game_over = 1'b0; tick = 1'b0;
    check("t6_dir", 32'(direction), 32'(IDLE));
    check("t6_strobe", 32'(move_strobe), 32'd0);
    check("t6_ovf", 32'(overflow), 32'd0);
    check("t6_full", 32'(queue_full), 32'd0);
    do_tick();
    check("t6_flushed_dir", 32'(direction), 32'(IDLE));
    check("t6_flushed_strobe", 32'(move_strobe), 32'd0);

    // Reset mid-operation with a tick pending
    press_kbd(LEFT);
    do_tick();
    check("rst2_pre_dir", 32'(direction), 32'(LEFT));
    press_btn(UP);
    reset_n = 1'b0; tick = 1'b1;
    step();
    reset_n = 1'b1; tick = 1'b0;
    check("rst2_dir", 32'(direction), 32'(IDLE));
    check("rst2_strobe", 32'(move_strobe), 32'd0);
    do_tick();
    check("rst2_empty_dir", 32'(direction), 32'(IDLE));

`ifdef TURN_SCHEDULER_PAUSE_EN
    press_btn(LEFT);
    do_tick();
    check("p_run_dir", 32'(direction), 32'(LEFT));
    press_btn(UP);
    pause = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      do_tick();
      check("p_blocked_strobe", 32'(move_strobe), 32'd0);
      check("p_blocked_dir", 32'(direction), 32'(LEFT));
    end
    pause = 1'b0;
    step();
    check("p_release_strobe", 32'(move_strobe), 32'd0);
    do_tick();
    check("p_resume_dir", 32'(direction), 32'(UP));
    check("p_resume_strobe", 32'(move_strobe), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
